// File: rtl/array_pkg.sv
// Shared types and default sizing for the array allocator and the execution units.
package array_pkg;

  localparam int NREQ_DEFAULT    = 4;
  localparam int NARRAYS_DEFAULT = 16;
  localparam int MEW_DEFAULT     = 12;

  typedef enum logic {
    OP_ALLOC = 1'b0,
    OP_FREE  = 1'b1
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/array_free_stack.sv
// LIFO of freed array handles; the caller guarantees no push when full and no pop when empty.
module array_free_stack
  import array_pkg::*;
#(
  parameter int Depth = NARRAYS_DEFAULT,
  parameter int Width = MEW_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic             empty,
  output logic [Width-1:0] top
);

  localparam int AW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int SPW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [SPW-1:0]   sp;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic             full;

  assign top_idx  = AW'(sp - SPW'(1));
  assign push_idx = AW'(sp);
  assign empty    = (sp == '0);
  assign full     = (sp == SPW'(Depth));
  assign top      = empty ? '0 : mem[top_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !pop && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !push && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  // Entry contents are don't-care until pushed, so the storage carries no reset.
  always_ff @(posedge clock) begin
    if (push && !pop && !full) begin
      mem[push_idx] <= push_data;
    end
  end

endmodule

// File: rtl/array_alloc_arbiter.sv
// Round-robin front end to the array allocator: fresh-handle counter, freed-handle LIFO
// and in-use bitmap, one alloc/free serviced every two cycles.
module array_alloc_arbiter
  import array_pkg::*;
#(
  parameter int NReq               = NREQ_DEFAULT,
  parameter int NArrays            = NARRAYS_DEFAULT,
  parameter int MemoryElementWidth = MEW_DEFAULT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    req_valid,
  input  logic [NReq-1:0]                    req_op,
  input  logic [NReq*MemoryElementWidth-1:0] req_array,
  output logic [NReq-1:0]                    resp_valid,
  output logic [MemoryElementWidth-1:0]      resp_array,
  output logic                               resp_error,
  output logic                               size_clear_valid,
  output logic [MemoryElementWidth-1:0]      size_clear_index,
  output logic [MemoryElementWidth-1:0]      in_use,
  output logic [MemoryElementWidth-1:0]      allocs
);

  localparam int W  = MemoryElementWidth;
  localparam int GW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1;

  state_t           state;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    winner;
  op_t              op;
  logic [W-1:0]     handle;
  logic [NArrays-1:0] used_map;

  logic             grant_found;
  logic [GW-1:0]    grant_idx;
  logic             stack_empty;
  logic [W-1:0]     stack_top;
  logic             alloc_from_stack;
  logic             alloc_fresh;
  logic             free_ok;
  logic [W-1:0]     alloc_handle;
  logic [AW-1:0]    alloc_idx;
  logic [AW-1:0]    handle_idx;
  logic             handle_in_range;

  // Search starts just after the last winner so a served requester drops to lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NReq; k++) begin
      logic [GW-1:0] cand;
      cand = GW'((int'(last_grant) + k) % NReq);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign handle_in_range  = (handle < W'(NArrays));
  assign handle_idx       = AW'(handle);
  assign alloc_from_stack = (state == SERVE) && (op == OP_ALLOC) && !stack_empty;
  assign alloc_fresh      = (state == SERVE) && (op == OP_ALLOC) && stack_empty
                            && (allocs < W'(NArrays));
  assign free_ok          = (state == SERVE) && (op == OP_FREE) && handle_in_range
                            && used_map[handle_idx];
  assign alloc_handle     = stack_empty ? allocs : stack_top;
  assign alloc_idx        = AW'(alloc_handle);

  array_free_stack #(
    .Depth (NArrays),
    .Width (W)
  ) u_free_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (free_ok),
    .pop       (alloc_from_stack),
    .push_data (handle),
    .empty     (stack_empty),
    .top       (stack_top)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= GW'(NReq - 1);
      winner           <= '0;
      op               <= OP_ALLOC;
      handle           <= '0;
      used_map         <= '0;
      in_use           <= '0;
      allocs           <= '0;
      resp_valid       <= '0;
      resp_array       <= '0;
      resp_error       <= 1'b0;
      size_clear_valid <= 1'b0;
      size_clear_index <= '0;
    end else begin
      resp_valid       <= '0;
      size_clear_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            winner <= grant_idx;
            op     <= op_t'(req_op[grant_idx]);
            handle <= req_array[grant_idx*W +: W];
            state  <= SERVE;
          end
        end
        SERVE: begin
          resp_valid[winner] <= 1'b1;
          last_grant         <= winner;
          state              <= IDLE;
          if (op == OP_ALLOC) begin
            if (alloc_from_stack || alloc_fresh) begin
              resp_array          <= alloc_handle;
              resp_error          <= 1'b0;
              used_map[alloc_idx] <= 1'b1;
              in_use              <= in_use + W'(1);
              size_clear_valid    <= 1'b1;
              size_clear_index    <= alloc_handle;
              if (alloc_fresh) begin
                allocs <= allocs + W'(1);
              end
            end else begin
              resp_array <= '0;
              resp_error <= 1'b1;
            end
          end else begin
            resp_array <= handle;
            resp_error <= !free_ok;
            if (free_ok) begin
              used_map[handle_idx] <= 1'b0;
              in_use               <= in_use - W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/array_alloc_arbiter.md
# array_alloc_arbiter

Shares the array allocator (fresh-array counter plus freed-array LIFO stack) between several requesters that issue `array` (alloc) and `free` operations. Arbitration is round-robin. Each accepted request is serviced in a fixed two-cycle sequence. Every alloc emits a size-clear strobe, so the array-size table entry for the returned handle is zeroed. The block sits between the instruction-execution units and the heap/arraySizes storage.

## Interface

Parameters:
- `NReq`, 4, number of requesters
- `NArrays`, 16, maximum number of arrays (handles `0..NArrays-1`)
- `MemoryElementWidth`, 12, width of an array handle

Ports:
- `clock`  in  1  driving clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NReq  request pending per requester; held high until its `resp_valid`
- `req_op`  in  NReq  per requester: 0 = alloc, 1 = free
- `req_array`  in  NReq*MemoryElementWidth  handle to free (requester r at bits `[r*W +: W]`)
- `resp_valid`  out  NReq  one-cycle pulse to the serviced requester
- `resp_array`  out  MemoryElementWidth  allocated handle; freed handle on free; 0 on alloc error
- `resp_error`  out  1  qualifies `resp_valid`: alloc exhausted, or invalid/double free
- `size_clear_valid`  out  1  pulse: zero `arraySizes[size_clear_index]`
- `size_clear_index`  out  MemoryElementWidth  handle to clear
- `in_use`  out  MemoryElementWidth  arrays currently allocated
- `allocs`  out  MemoryElementWidth  high-water count of fresh handles issued

## Operation

- State: `IDLE`, `SERVE`.
- `IDLE`: if any `req_valid` is high, pick the winner round-robin, starting from the requester after `last_grant`. Latch winner, op and handle. Go to `SERVE`. With no request, stay in `IDLE`.
- `SERVE`: execute the op, pulse `resp_valid[winner]`, set `last_grant` = winner, return to `IDLE`.
- Alloc:
  - If the free stack is non-empty, pop its top (LIFO).
  - Else, if `allocs < NArrays`, return `allocs` and increment `allocs`.
  - Else, error: `resp_array` = 0, no state change.
  - On success: set the in-use bitmap bit, increment `in_use`, and pulse `size_clear_valid` in the same cycle with the returned handle.
- Free:
  - Error if handle ≥ `NArrays` or its in-use bit is clear. State is unchanged.
  - Otherwise push the handle onto the stack, clear its bit and decrement `in_use`.
  - The stack cannot overflow, because the bitmap rejects double frees.
- `req_valid` dropping before its response: the latched op still executes. The response is still pulsed and is ignored by the requester.
- `req_op`/`req_array` are sampled only in `IDLE` on the grant cycle.

## Timing

- Reset values:
  - `resp_valid` = 0, `resp_array` = 0, `resp_error` = 0.
  - `size_clear_valid` = 0, `size_clear_index` = 0.
  - `in_use` = 0, `allocs` = 0.
  - Stack top = 0, bitmap all 0, `last_grant` = `NReq-1` (requester 0 has first priority), state `IDLE`.
- Latency: request seen high at edge t → `resp_valid` high for the cycle after edge t+1. Throughput is one op per 2 cycles.
- All outputs are registered; `resp_*` and `size_clear_*` are single-cycle pulses. `resp_array`/`resp_error` hold until the next response.
- Requester holding `req_valid` through its own response: it re-arbitrates the next `IDLE` cycle and receives lowest priority.
- Reset mid-`SERVE`: the op is discarded and no pulse is produced. The allocator state is fully cleared; outstanding handles are lost by design.

## Structure

- Package `array_pkg`: `op_t` (`OP_ALLOC`=0, `OP_FREE`=1), `state_t`, and the default `NArrays`/`MemoryElementWidth` constants shared with the execution units.
- Sub-module `array_free_stack`: LIFO of depth `NArrays`, with push, pop, empty and top signals. The arbiter FSM, round-robin pointer, bitmap and counters stay in `array_alloc_arbiter`.

## Test plan

- Single alloc from req 0 after reset → handle 0, `size_clear_valid`/index 0, `in_use`=1, `allocs`=1, response on the 2nd cycle after request.
- Reqs 0–3 all alloc together, held → served in order 0,1,2,3 with handles 0,1,2,3 on every other cycle.
- Alloc 0,1,2; free 1 then free 0; alloc twice → handles 0 then 1 (LIFO), `allocs` stays 3.
- Free handle 5 (never allocated), then free 0 twice → errors on handle 5 and on the second free of 0, with no change to `in_use`.
- Allocate 16 with `NArrays`=16, then a 17th alloc → `resp_error`=1, `resp_array`=0, no `size_clear_valid`.
- Assert reset during `SERVE` → no `resp_valid`, and all outputs return to 0 the following cycle.
